// File: rtl/shreg_tx_ctrl.sv
// Serial transmit sequencer for an external shift-left/zero-fill register:
// buffers one word, loads it into shreg, then frames the MSB-first bit stream.
module shreg_tx_ctrl #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sh_ld,
  output logic [WIDTH-1:0] sh_d,
  input  logic [WIDTH-1:0] sh_q,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int                CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]     CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [3:0]        GCNT_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t           state_q, state_d;
  logic             hold_vld_q, hold_vld_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             sh_ld_q, sh_ld_d;
  logic [WIDTH-1:0] sh_d_q, sh_d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic             fire;
  logic             launch;
  logic             unused_sh_q;

  // Handshake: a word transfers on a rising edge where in_valid & in_ready;
  // in_ready depends only on rst_n and the buffer flag, never on in_valid.
  assign in_ready = rst_n & ~hold_vld_q;
  assign fire     = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    sh_ld_d     = 1'b0;
    sh_d_d      = sh_d_q;
    cnt_d       = cnt_q;
    gcnt_d      = gcnt_q;
    launch      = 1'b0;

    if (fire) begin
      hold_vld_d  = 1'b1;
      hold_data_d = in_data;
    end

    case (state_q)
      S_IDLE: begin
        if (hold_vld_q) launch = 1'b1;
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
      end
      S_SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (GAP > 0) begin
          state_d = S_GAP;
          gcnt_d  = '0;
        end else if (hold_vld_q) begin
          launch = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        gcnt_d = gcnt_q + 1'b1;
        if (gcnt_q == GCNT_LAST) begin
          if (hold_vld_q) launch = 1'b1;
          else            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Launch only happens with the buffer full, so it never collides with fire.
    if (launch) begin
      state_d    = S_LOAD;
      sh_ld_d    = 1'b1;
      sh_d_d     = hold_data_q;
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      sh_ld_q     <= 1'b0;
      sh_d_q      <= '0;
      cnt_q       <= '0;
      gcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      sh_ld_q     <= sh_ld_d;
      sh_d_q      <= sh_d_d;
      cnt_q       <= cnt_d;
      gcnt_q      <= gcnt_d;
    end
  end

  assign sh_ld     = sh_ld_q;
  assign sh_d      = sh_d_q;
  // Only the register MSB matters, and only while shifting.
  assign ser_valid = (state_q == S_SHIFT);
  assign ser_bit   = ser_valid & sh_q[WIDTH-1];
  assign ser_first = ser_valid & (cnt_q == '0);
  assign ser_last  = ser_valid & (cnt_q == CNT_LAST);
  assign busy      = (state_q != S_IDLE) | hold_vld_q;
  assign dbg_state = state_q;

  assign unused_sh_q = ^sh_q[WIDTH-2:0];

endmodule
